// File: rtl/demux_rr_dispatcher_if.sv
// demux_rr_dispatcher_if: input stream and 1-to-4 demux offer signals of the dispatcher
interface demux_rr_dispatcher_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              en;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        sel;
  logic [CNT_W-1:0]  xfer_cnt;
  modport slave (
    input  en, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sel, xfer_cnt
  );
  modport master (
    output en, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel, xfer_cnt
  );
endinterface

// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher: single-entry buffer that deals items round-robin over four channels
module demux_rr_dispatcher #(
  parameter int DATA_W    = 8,
  parameter int SKIP_BUSY = 1,
  parameter int CNT_W     = 16
) (
  input logic clk,
  input logic rst,
  demux_rr_dispatcher_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t            r_state, w_state_nxt;
  logic [1:0]        r_ptr, r_sel, w_ptr_nxt, w_pick, w_sel_ld;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_acc, w_load;
  assign w_acc     = (r_state == FULL) && bus.out_ready[r_sel];
  assign bus.in_ready = bus.en && ((r_state == EMPTY) || w_acc);
  assign w_load    = bus.in_valid && bus.in_ready;
  assign w_ptr_nxt = w_acc ? r_sel + 2'd1 : r_ptr;
  // descending scan so the nearest ready channel after ptr_nxt wins
  always_comb begin
    w_pick = w_ptr_nxt;
    for (int k = 3; k >= 0; k--)
      if (bus.out_ready[w_ptr_nxt + 2'(k)]) w_pick = w_ptr_nxt + 2'(k);
  end
  assign w_sel_ld = (SKIP_BUSY != 0) ? w_pick : w_ptr_nxt;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_load ? FULL : (w_acc ? EMPTY : r_state);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ptr  <= '0;
      r_sel  <= '0;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_load) begin
        r_sel  <= w_sel_ld;
        r_data <= bus.in_data;
      end
      if (w_acc) begin
        r_ptr <= r_sel + 2'd1;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  assign bus.out_valid = (r_state == FULL) ? 4'b0001 << r_sel : 4'b0000;
  assign bus.out_data  = r_data;
  assign bus.sel       = r_sel;
  assign bus.xfer_cnt  = r_cnt;
endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// tb_demux_rr_dispatcher: directed vector table plus hand sequences over strict, skip and narrow-counter builds
module tb_demux_rr_dispatcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  demux_rr_dispatcher_if #(.DATA_W(8), .CNT_W(16)) u0 ();
  demux_rr_dispatcher_if #(.DATA_W(8), .CNT_W(16)) u1 ();
  demux_rr_dispatcher_if #(.DATA_W(8), .CNT_W(4))  u2 ();
  demux_rr_dispatcher #(.DATA_W(8), .SKIP_BUSY(0), .CNT_W(16)) d0 (.clk(clk), .rst(rst), .bus(u0));
  demux_rr_dispatcher #(.DATA_W(8), .SKIP_BUSY(1), .CNT_W(16)) d1 (.clk(clk), .rst(rst), .bus(u1));
  demux_rr_dispatcher #(.DATA_W(8), .SKIP_BUSY(0), .CNT_W(4))  d2 (.clk(clk), .rst(rst), .bus(u2));
  logic [3:0]  a_ov[3];
  logic        a_ir[3];
  logic [1:0]  a_sel[3];
  logic [7:0]  a_dat[3];
  logic [15:0] a_cnt[3];
  assign a_ov[0] = u0.out_valid;  assign a_ov[1] = u1.out_valid;  assign a_ov[2] = u2.out_valid;
  assign a_ir[0] = u0.in_ready;   assign a_ir[1] = u1.in_ready;   assign a_ir[2] = u2.in_ready;
  assign a_sel[0] = u0.sel;       assign a_sel[1] = u1.sel;       assign a_sel[2] = u2.sel;
  assign a_dat[0] = u0.out_data;  assign a_dat[1] = u1.out_data;  assign a_dat[2] = u2.out_data;
  assign a_cnt[0] = u0.xfer_cnt;  assign a_cnt[1] = u1.xfer_cnt;  assign a_cnt[2] = 16'(u2.xfer_cnt);
  typedef struct {
    int         dut;
    bit         rs, en, v;
    logic [7:0] d;
    logic [3:0] r, ov;
    bit         ir;
    logic [1:0] sel;
    logic [7:0] dat;
    logic [15:0] cnt;
  } row_t;
  row_t tbl[$];
  int checks = 0;
  int errors = 0;
  function automatic row_t mk(int dut, bit rs, bit en, bit v, logic [7:0] d, logic [3:0] r,
                              logic [3:0] ov, bit ir, logic [1:0] sel, logic [7:0] dat, logic [15:0] cnt);
    row_t t;
    t.dut = dut; t.rs = rs; t.en = en; t.v = v; t.d = d; t.r = r;
    t.ov = ov; t.ir = ir; t.sel = sel; t.dat = dat; t.cnt = cnt;
    return t;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask
  task automatic drive(bit en, bit v, logic [7:0] d, logic [3:0] r);
    u0.en = en; u0.in_valid = v; u0.in_data = d; u0.out_ready = r;
    u1.en = en; u1.in_valid = v; u1.in_data = d; u1.out_ready = r;
    u2.en = en; u2.in_valid = v; u2.in_data = d; u2.out_ready = r;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 4'h0);
    tick;
    rst = 1'b0;
  endtask
  initial begin
    drive(1'b0, 1'b0, 8'h00, 4'h0);
    #12;
    // test 1: strict rotation, all consumers ready
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 4'hF, 4'h0, 0, 2'd0, 8'h00, 16'd0));
    tbl.push_back(mk(0, 0, 1, 1, 8'hA0, 4'hF, 4'h0, 1, 2'd0, 8'h00, 16'd0));
    for (int k = 1; k < 8; k++)
      tbl.push_back(mk(0, 0, 1, 1, 8'(8'hA0 + k), 4'hF, 4'(1 << ((k - 1) % 4)), 1,
                       2'((k - 1) % 4), 8'(8'hA0 + k - 1), 16'(k - 1)));
    tbl.push_back(mk(0, 0, 1, 0, 8'h00, 4'hF, 4'h8, 1, 2'd3, 8'hA7, 16'd7));
    tbl.push_back(mk(0, 0, 1, 0, 8'h00, 4'hF, 4'h0, 1, 2'd3, 8'h00, 16'd8));
    // test 2: strict stall on channel 0
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 4'hF, 4'h0, 0, 2'd0, 8'h00, 16'd0));
    tbl.push_back(mk(0, 0, 1, 1, 8'h55, 4'hE, 4'h0, 1, 2'd0, 8'h00, 16'd0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h00, 4'hE, 4'h1, 0, 2'd0, 8'h55, 16'd0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h00, 4'hE, 4'h1, 0, 2'd0, 8'h55, 16'd0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h00, 4'hF, 4'h1, 1, 2'd0, 8'h55, 16'd0));
    tbl.push_back(mk(0, 0, 1, 1, 8'h66, 4'hF, 4'h0, 1, 2'd0, 8'h00, 16'd1));
    tbl.push_back(mk(0, 0, 1, 0, 8'h00, 4'hF, 4'h2, 1, 2'd1, 8'h66, 16'd1));
    tbl.push_back(mk(0, 0, 1, 0, 8'h00, 4'hF, 4'h0, 1, 2'd1, 8'h00, 16'd2));
    // test 3: skip busy channels, including a back-to-back load with skip
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 4'hF, 4'h0, 0, 2'd0, 8'h00, 16'd0));
    tbl.push_back(mk(1, 0, 1, 1, 8'h77, 4'h4, 4'h0, 1, 2'd0, 8'h00, 16'd0));
    tbl.push_back(mk(1, 0, 1, 0, 8'h00, 4'hF, 4'h4, 1, 2'd2, 8'h77, 16'd0));
    tbl.push_back(mk(1, 0, 1, 1, 8'h88, 4'hF, 4'h0, 1, 2'd2, 8'h00, 16'd1));
    tbl.push_back(mk(1, 0, 1, 0, 8'h00, 4'hF, 4'h8, 1, 2'd3, 8'h88, 16'd1));
    tbl.push_back(mk(1, 0, 1, 1, 8'h99, 4'h2, 4'h0, 1, 2'd3, 8'h00, 16'd2));
    tbl.push_back(mk(1, 0, 1, 1, 8'hAA, 4'h2, 4'h2, 1, 2'd1, 8'h99, 16'd2));
    tbl.push_back(mk(1, 0, 1, 0, 8'h00, 4'hF, 4'h2, 1, 2'd1, 8'hAA, 16'd3));
    tbl.push_back(mk(1, 0, 1, 0, 8'h00, 4'hF, 4'h0, 1, 2'd1, 8'h00, 16'd4));
    foreach (tbl[i]) begin
      rst = tbl[i].rs;
      drive(tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].r);
      #1;
      chk($sformatf("row%0d out_valid", i), 32'(a_ov[tbl[i].dut]), 32'(tbl[i].ov));
      chk($sformatf("row%0d in_ready", i), 32'(a_ir[tbl[i].dut]), 32'(tbl[i].ir));
      chk($sformatf("row%0d sel", i), 32'(a_sel[tbl[i].dut]), 32'(tbl[i].sel));
      chk($sformatf("row%0d xfer_cnt", i), 32'(a_cnt[tbl[i].dut]), 32'(tbl[i].cnt));
      if (tbl[i].ov != 4'h0)
        chk($sformatf("row%0d out_data", i), 32'(a_dat[tbl[i].dut]), 32'(tbl[i].dat));
      @(posedge clk);
      #1;
    end
    // test 4: en dropped while an offer is pending
    do_reset;
    drive(1'b1, 1'b1, 8'h99, 4'h0);
    #1 chk("en_drop ir_before", 32'(u0.in_ready), 32'd1);
    tick;
    drive(1'b0, 1'b1, 8'h12, 4'h0);
    #1 chk("en_drop ov_held", 32'(u0.out_valid), 32'h1);
    chk("en_drop ir_low", 32'(u0.in_ready), 32'd0);
    chk("en_drop data", 32'(u0.out_data), 32'h99);
    tick;
    chk("en_drop ov_held2", 32'(u0.out_valid), 32'h1);
    chk("en_drop data2", 32'(u0.out_data), 32'h99);
    drive(1'b0, 1'b1, 8'h12, 4'hF);
    #1 chk("en_drop ir_on_acc", 32'(u0.in_ready), 32'd0);
    tick;
    chk("en_drop ov_empty", 32'(u0.out_valid), 32'h0);
    chk("en_drop ir_after", 32'(u0.in_ready), 32'd0);
    chk("en_drop cnt", 32'(u0.xfer_cnt), 32'd1);
    tick;
    chk("en_drop stays_empty", 32'(u0.out_valid), 32'h0);
    // test 5: asynchronous reset in the middle of an offer
    do_reset;
    drive(1'b1, 1'b1, 8'h11, 4'hF);
    tick;
    drive(1'b1, 1'b0, 8'h00, 4'hF);
    tick;
    drive(1'b1, 1'b1, 8'h22, 4'h4);
    tick;
    drive(1'b1, 1'b0, 8'h00, 4'h0);
    #1 chk("arst ov_before", 32'(u1.out_valid), 32'h4);
    chk("arst cnt_before", 32'(u1.xfer_cnt), 32'd1);
    #2 rst = 1'b1;
    #1 chk("arst ov", 32'(u1.out_valid), 32'h0);
    chk("arst sel", 32'(u1.sel), 32'd0);
    chk("arst cnt", 32'(u1.xfer_cnt), 32'd0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 8'h33, 4'hF);
    tick;
    chk("arst next_ov", 32'(u1.out_valid), 32'h1);
    chk("arst next_sel", 32'(u1.sel), 32'd0);
    chk("arst next_data", 32'(u1.out_data), 32'h33);
    // test 6: 4-bit transfer counter wraps after 16 transfers
    do_reset;
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, i < 17, 8'(i), 4'hF);
      #1;
      if (i > 0) begin
        chk($sformatf("wrap sel%0d", i), 32'(u2.sel), 32'((i - 1) % 4));
        chk($sformatf("wrap ov%0d", i), 32'(u2.out_valid), 32'(1 << ((i - 1) % 4)));
      end
      if (i == 17) chk("wrap cnt16", 32'(u2.xfer_cnt), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("wrap cnt17", 32'(u2.xfer_cnt), 32'd1);
    chk("wrap empty", 32'(u2.out_valid), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
